uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one uart_tx transmitter between NUM_REQ byte-stream requesters.
//  Round-robin arbitration is per packet: a grant is held until the requester's
//  byte flagged last has fully left the wire, so packets never interleave.
//  Sits between protocol/debug sources (SPC700 trace, register dump) and uart_tx.
// PARAMETERS
//  NUM_REQ         4    number of requesters (2..8)
//  TIMEOUT_CYCLES  4096 idle cycles allowed mid-packet before forced release (UART_SCHED_TIMEOUT_EN only)
// PORTS
//  clock                in   1          system clock, all logic on posedge
//  reset                in   1          synchronous, active-high
//  req_valid            in   NUM_REQ    requester i has a byte on req_data[8i+7:8i]
//  req_data             in   8*NUM_REQ  packed request bytes
//  req_last             in   NUM_REQ    byte from requester i ends its packet
//  req_ready            out  NUM_REQ    one-hot, combinational; transfer = valid&ready
//  tx_byte_out          out  8          to uart_tx byte_out (registered)
//  tx_write_trigger     out  1          to uart_tx write_trigger, 1-cycle pulse (registered)
//  tx_ready_to_transmit in   1          from uart_tx ready_to_transmit
//  grant_id             out  clog2(NUM_REQ)  current/last granted requester
//  busy                 out  1          high in any state except IDLE
//  timeout_pulse        out  1          1-cycle pulse on forced release
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, tx_write_trigger=0, tx_byte_out=8'h00,
//   grant_id=0, busy=0, timeout_pulse=0, rr pointer=NUM_REQ-1 (req 0 wins first).
//  States: IDLE, LOAD, WAIT_START, WAIT_DONE.
//  IDLE: if any req_valid: grant first valid index searching from pointer+1
//   with wrap-around; latch grant_id; -> LOAD. No byte is accepted in IDLE.
//  LOAD: req_ready[grant_id] = tx_ready_to_transmit (all other bits 0).
//   On transfer: tx_byte_out<=req_data[grant], tx_write_trigger<=1 for exactly
//   one cycle, latch last flag; -> WAIT_START.
//  WAIT_START: wait for tx_ready_to_transmit==0 (uart_tx accepted) -> WAIT_DONE.
//  WAIT_DONE: wait for tx_ready_to_transmit==1 (stop bit complete); then if latched
//   last: pointer<=grant_id, -> IDLE; else -> LOAD (same grant).
//  Latency: valid in IDLE -> req_ready earliest 1 cycle later; transfer ->
//   trigger at uart_tx the following cycle; next byte of a packet accepted
//   one frame + 2 cycles after previous transfer.
//  Non-granted valid inputs are ignored and never stalled-out-of-order; a valid
//   arriving while another packet is in progress waits for packet end.
//  Single requester back-to-back packets: re-granted, other valids still win per rr.
//  req_valid dropped mid-packet: grant held in LOAD indefinitely (see CONFIG).
//  tx_ready_to_transmit low in LOAD (uart_tx busy from external reset skew):
//   req_ready held 0, no transfer.
//  Reset mid-packet: immediate return to reset values; partial packet dropped;
//   uart_tx shares reset so line returns high.
// CONFIGURATION
//  UART_SCHED_TIMEOUT_EN defined: 16-bit counter runs in LOAD while
//   req_valid[grant_id]==0, clears on transfer or state exit; on reaching
//   TIMEOUT_CYCLES-1: timeout_pulse=1 one cycle, pointer<=grant_id, -> IDLE.
//  Undefined: no counter, timeout_pulse tied 0, TIMEOUT_CYCLES unused.
// TESTING (uart_tx instantiated, CLOCKS_PER_BIT=4, NUM_REQ=4)
//  Reset, req0 sends 8'hA5 last=1 -> one trigger, line shows 0,1010 0101(LSB first),1; busy then 0.
//  req1 3-byte packet (11,22,33) + req2 valid 8'h44 at same time -> line order 11,22,33,44.
//  All four valid continuously, 1-byte packets -> grant_id sequence 0,1,2,3,0,1.
//  req0 sends byte (last=0) then drops valid; req3 valid -> req3 never granted
//   (timeout off); with UART_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16 -> timeout_pulse
//   after 16 idle cycles, then req3 transmits.
//  Assert reset during data bit 3 of a frame -> next cycle all outputs at reset
//   values, line high, following packet from req0 transmits cleanly.
//  Check req_ready never has >1 bit set and tx_write_trigger never high 2 cycles.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares a single uart_tx between NUM_REQ byte-stream requesters.
//   Arbitration is round-robin per packet: once granted, a requester keeps
//   the transmitter until its byte flagged last has completely left the
//   wire (uart_tx reports ready again), so packets never interleave.
//
//   Optional feature macro: UART_SCHED_TIMEOUT_EN
//     defined   -> a requester that stalls mid-packet for TIMEOUT_CYCLES
//                  cycles loses the grant and timeout pulses once.
//     undefined -> grant is held indefinitely, timeout is tied low.
//
//   Reset is synchronous and active-high.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int GW            = $clog2(NUM_REQ)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_byte_out,
  output logic                 o_tx_write_trigger,
  input  logic                 i_tx_ready_to_transmit,
  output logic [GW-1:0]        o_grant_id,
  output logic                 o_busy,
  output logic                 o_timeout_pulse
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_LOAD       = 2'd1;
  localparam logic [1:0] S_WAIT_START = 2'd2;
  localparam logic [1:0] S_WAIT_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [GW-1:0] r_ptr;
  logic [GW-1:0] r_grant;
  logic          r_last;
  logic [7:0]    r_tx_byte;
  logic          r_trig;

  logic          w_arb_found;
  logic [GW-1:0] w_arb_idx;
  logic          w_sel_valid;
  logic          w_sel_last;
  logic [7:0]    w_sel_data;
  logic          w_xfer;
  logic          w_timeout;

  // Round-robin search: first valid requester after the pointer, wrapping.
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    int w_cand;
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = int'(r_ptr) + k;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      if (!w_arb_found && i_req_valid[w_cand[GW-1:0]]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand[GW-1:0];
      end
    end
  end

  // Signals of the currently granted requester.
  assign w_sel_valid = i_req_valid[r_grant];
  assign w_sel_last  = i_req_last[r_grant];
  assign w_sel_data  = i_req_data[{r_grant, 3'b000} +: 8];

  // Ready goes only to the granted requester, only in LOAD and only while
  // uart_tx can take a byte, so it is one-hot or zero by construction.
  always_comb begin
    o_req_ready = '0;
    if (r_state == S_LOAD && i_tx_ready_to_transmit) o_req_ready[r_grant] = 1'b1;
  end

  assign w_xfer = (r_state == S_LOAD) && i_tx_ready_to_transmit && w_sel_valid;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_idle_cnt;
  logic        r_timeout_pulse;

  assign w_timeout = (r_state == S_LOAD) && !w_sel_valid && (r_idle_cnt == TIMEOUT_LAST);

  // Count cycles the granted requester leaves LOAD starved; pulse on expiry.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_idle_cnt      <= '0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_timeout_pulse <= w_timeout;
      if (r_state != S_LOAD || w_xfer || w_timeout) r_idle_cnt <= '0;
      else if (!w_sel_valid)                         r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end

  assign o_timeout_pulse = r_timeout_pulse;
`else
  assign w_timeout       = 1'b0;
  assign o_timeout_pulse = 1'b0;
`endif

  // Packet scheduler FSM: grant, hand one byte to uart_tx, track its frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= GW'(NUM_REQ - 1);
      r_grant   <= '0;
      r_last    <= 1'b0;
      r_tx_byte <= 8'h00;
      r_trig    <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_arb_found) begin
            r_grant <= w_arb_idx;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_tx_byte <= w_sel_data;
            r_trig    <= 1'b1;
            r_last    <= w_sel_last;
            r_state   <= S_WAIT_START;
          end else if (w_timeout) begin
            r_ptr   <= r_grant;
            r_state <= S_IDLE;
          end
        end
        S_WAIT_START: begin
          // uart_tx drops ready once it has latched the byte.
          if (!i_tx_ready_to_transmit) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // Ready returns after the stop bit; only then is the wire free.
          if (i_tx_ready_to_transmit) begin
            if (r_last) begin
              r_ptr   <= r_grant;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_byte_out      = r_tx_byte;
  assign o_tx_write_trigger = r_trig;
  assign o_grant_id         = r_grant;
  assign o_busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler with a behavioural uart_tx (4 clocks/bit).
// Requester byte queues feed the DUT; every expected (grant, byte) write to
// uart_tx is queued when stimulus is issued and popped by a monitor.
// Build with +define+UART_SCHED_TIMEOUT_EN to exercise the forced release.
module tb_uart_tx_scheduler;
  localparam int NUM_REQ = 4;
  localparam int CPB     = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_byte;
  logic                 tx_trig;
  logic                 tx_rdy;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 tpulse;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(16)) dut (
    .i_clock               (clk),
    .i_reset               (reset),
    .i_req_valid           (req_valid),
    .i_req_data            (req_data),
    .i_req_last            (req_last),
    .o_req_ready           (req_ready),
    .o_tx_byte_out         (tx_byte),
    .o_tx_write_trigger    (tx_trig),
    .i_tx_ready_to_transmit(tx_rdy),
    .o_grant_id            (grant_id),
    .o_busy                (busy),
    .o_timeout_pulse       (tpulse)
  );

  // Behavioural uart_tx: start bit, 8 data bits LSB first, stop bit.
  logic       line;
  logic       u_busy;
  logic [9:0] u_shift;
  int         u_bit;
  int         u_cnt;

  always @(posedge clk) begin
    if (reset) begin
      line <= 1'b1; tx_rdy <= 1'b1; u_busy <= 1'b0;
      u_bit <= 0; u_cnt <= 0; u_shift <= '1;
    end else if (!u_busy) begin
      if (tx_trig) begin
        u_shift <= {1'b1, tx_byte, 1'b0};
        line <= 1'b0; tx_rdy <= 1'b0; u_busy <= 1'b1;
        u_bit <= 0; u_cnt <= 0;
      end
    end else if (u_cnt == CPB - 1) begin
      u_cnt <= 0;
      if (u_bit == 9) begin
        u_busy <= 1'b0; tx_rdy <= 1'b1; line <= 1'b1;
      end else begin
        u_bit <= u_bit + 1;
        line  <= u_shift[u_bit + 1];
      end
    end else begin
      u_cnt <= u_cnt + 1;
    end
  end

  typedef struct packed { logic [7:0] data; logic last; } item_t;
  typedef struct packed { logic [1:0] gid;  logic [7:0] data; } exp_t;

  item_t req_q[NUM_REQ][$];
  exp_t  exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_viol  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_req(input int r, input logic [7:0] d, input logic l);
    item_t it;
    it.data = d; it.last = l;
    req_q[r].push_back(it);
  endtask

  task automatic push_exp(input logic [1:0] g, input logic [7:0] d);
    exp_t e;
    e.gid = g; e.data = d;
    exp_q.push_back(e);
  endtask

  // Requester driver: a visible trigger means the granted requester's head
  // byte was taken at the previous edge, so it is retired here.
  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      if (tx_trig && req_q[grant_id].size() > 0) void'(req_q[grant_id].pop_front());
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_q[r].size() > 0) begin
          req_valid[r]         = 1'b1;
          req_data[8*r +: 8]   = req_q[r][0].data;
          req_last[r]          = req_q[r][0].last;
        end else begin
          req_valid[r]         = 1'b0;
          req_data[8*r +: 8]   = 8'h00;
          req_last[r]          = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every uart_tx write against the scoreboard, and track
  // the one-hot ready and single-cycle trigger invariants.
  initial begin
    logic prev_trig;
    exp_t e;
    prev_trig = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if ($countones(req_ready) > 1) n_viol++;
        if (tx_trig && prev_trig) n_viol++;
        if (tx_trig) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_write: got byte %0h grant %0d expected none", tx_byte, grant_id);
          end else begin
            e = exp_q.pop_front();
            check("write_byte", 32'(tx_byte), 32'(e.data));
            check("write_grant", 32'(grant_id), 32'(e.gid));
          end
        end
        prev_trig = tx_trig;
      end else begin
        prev_trig = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait until all stimulus is consumed, expectations met and the DUT idle.
  task automatic wait_done(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && tx_rdy &&
          req_q[0].size() == 0 && req_q[1].size() == 0 &&
          req_q[2].size() == 0 && req_q[3].size() == 0) done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   32'(req_ready), 32'd0);
    check({tag, "_trig"},    32'(tx_trig),   32'd0);
    check({tag, "_byte"},    32'(tx_byte),   32'h00);
    check({tag, "_grant"},   32'(grant_id),  32'd0);
    check({tag, "_busy"},    32'(busy),      32'd0);
    check({tag, "_timeout"}, 32'(tpulse),    32'd0);
    check({tag, "_line"},    32'(line),      32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    int   cyc;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    // 1: single one-byte packet from req0.
    push_req(0, 8'hA5, 1'b1); push_exp(2'd0, 8'hA5);
    wait_done("t1_done", 200);
    check("t1_busy_end", 32'(busy), 32'd0);

    // 2: req1 three-byte packet competes with req2; no interleaving.
    push_req(1, 8'h11, 1'b0); push_req(1, 8'h22, 1'b0); push_req(1, 8'h33, 1'b1);
    push_req(2, 8'h44, 1'b1);
    push_exp(2'd1, 8'h11); push_exp(2'd1, 8'h22); push_exp(2'd1, 8'h33);
    push_exp(2'd2, 8'h44);
    wait_done("t2_done", 600);
    check("t2_last_grant", 32'(grant_id), 32'd2);

    // 3: all four requesters continuously valid -> 0,1,2,3,0,1.
    do_reset();
    push_req(0, 8'h60, 1'b1); push_req(0, 8'h64, 1'b1);
    push_req(1, 8'h61, 1'b1); push_req(1, 8'h65, 1'b1);
    push_req(2, 8'h62, 1'b1);
    push_req(3, 8'h63, 1'b1);
    push_exp(2'd0, 8'h60); push_exp(2'd1, 8'h61); push_exp(2'd2, 8'h62);
    push_exp(2'd3, 8'h63); push_exp(2'd0, 8'h64); push_exp(2'd1, 8'h65);
    wait_done("t3_done", 900);

    // 4: req0 stalls mid-packet while req3 waits.
    do_reset();
    push_req(0, 8'h77, 1'b0); push_exp(2'd0, 8'h77);
    push_req(3, 8'h33, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_rdy) seen = 1'b1;
    end
    check("t4_frame_started", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (tx_rdy) seen = 1'b1;
    end
    check("t4_frame_ended", 32'(seen), 32'd1);
`ifdef UART_SCHED_TIMEOUT_EN
    // Ready back at cycle 0; FSM enters LOAD one edge later, then 16 starved
    // cycles expire, and the pulse shows after the 17th edge.
    seen = 1'b0; cyc = 0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clk);
      if (tpulse) begin seen = 1'b1; cyc = c; end
    end
    check("t4_timeout_seen", 32'(seen), 32'd1);
    check("t4_timeout_delay", 32'(cyc), 32'd17);
    push_exp(2'd3, 8'h33);
    @(negedge clk);
    check("t4_timeout_width", 32'(tpulse), 32'd0);
    wait_done("t4_req3_done", 200);
`else
    cyc = 0;
    repeat (200) @(negedge clk);
    check("t4_hold_busy", 32'(busy), 32'd1);
    check("t4_hold_grant", 32'(grant_id), 32'd0);
    check("t4_hold_ready", 32'(req_ready), 32'b0001);
    check("t4_hold_timeout", 32'(tpulse), 32'd0);
    check("t4_req3_pending", 32'(req_q[3].size()), 32'd1);
    // Reset is the only way out without the timeout; req3 then goes.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    push_exp(2'd3, 8'h33);
    wait_done("t4_req3_done", 200);
`endif

    // 5: reset asserted during data bit 3, then a clean packet.
    do_reset();
    push_req(0, 8'h5A, 1'b1); push_exp(2'd0, 8'h5A);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (u_busy && u_bit == 4) seen = 1'b1;
    end
    check("t5_reached_bit3", 32'(seen), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    reset = 1'b0;
    push_req(0, 8'hC3, 1'b1); push_exp(2'd0, 8'hC3);
    wait_done("t5_done", 200);

    check("invariants", 32'(n_viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
